// File: rtl/traffic_pkg.sv
// Shared phase/FSM types and phase duration lookup for the
// traffic phase timer.
package traffic_pkg;

  typedef enum logic [2:0] {
    MGREEN,
    SGREEN,
    YELLOW,
    ALLRED,
    PED,
    ILLEGAL
  } phase_t;

  typedef enum logic [1:0] {
    SETTLE,
    LOAD,
    COUNT,
    PULSE
  } tstate_t;

  // ILLEGAL falls back to the all-red time; zero is stretched to 1 s
  function automatic int phase_dur(
    input phase_t p,
    input int     t_mg,
    input int     t_sg,
    input int     t_y,
    input int     t_ar,
    input int     t_ped
  );
    int d;
    case (p)
      MGREEN:  d = t_mg;
      SGREEN:  d = t_sg;
      YELLOW:  d = t_y;
      PED:     d = t_ped;
      default: d = t_ar;
    endcase
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/traffic_phase_timer_prescaler.sv
// One-second tick generator: counts 0..CLK_DIV-1, strobes on wrap,
// restarts from 0 on a synchronous clear.
module tick_prescaler #(
  parameter int CLK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  output logic o_tick
);

  localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  logic [PW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap = (r_cnt == PW'(CLK_DIV - 1));
  assign o_tick = w_wrap;

  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_cnt <= '0;
    end else if (w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + PW'(1);
    end
  end

endmodule

// File: rtl/traffic_phase_timer.sv
// Phase timer for the traffic light controller; optional illegal-
// pattern fault handling is built in with `define PHASE_FAULT_EN.
module traffic_phase_timer
  import traffic_pkg::*;
#(
  parameter int CLK_DIV  = 50_000_000,
  parameter int T_MGREEN = 20,
  parameter int T_SGREEN = 10,
  parameter int T_YELLOW = 3,
  parameter int T_ALLRED = 1,
  parameter int T_PED    = 8,
  parameter int CNT_W    = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MG,
  input  logic             MY,
  input  logic             MR,
  input  logic             SG,
  input  logic             SY,
  input  logic             SR,
  input  logic             pedLight,
  input  logic             newCycle,
  output logic             en,
  output logic             tick,
  output logic [CNT_W-1:0] remaining,
  output logic [7:0]       cycleCount,
  output logic             phaseFault
);

  logic [2:0]       r_main;
  logic [2:0]       r_side;
  logic             r_ped;
  logic             r_nc;
  logic [7:0]       r_cyc;
  logic [CNT_W-1:0] r_rem;
  phase_t           r_phase;
  tstate_t          r_state;

  phase_t           w_phase;
  tstate_t          w_state_nx;
  logic [CNT_W-1:0] w_dur;
  logic             w_tick;
  logic             w_clr;
  logic             w_reload;
  logic             w_load_ok;
  logic             w_fault;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_main <= '0;
      r_side <= '0;
      r_ped  <= 1'b0;
    end else begin
      r_main <= {MG, MY, MR};
      r_side <= {SG, SY, SR};
      r_ped  <= pedLight;
    end
  end

  always_comb begin
    w_phase = ILLEGAL;
    case ({r_main, r_side})
      6'b100_001: w_phase = MGREEN;
      6'b010_001: w_phase = YELLOW;
      6'b001_001: w_phase = r_ped ? PED : ALLRED;
      6'b001_100: w_phase = SGREEN;
      6'b001_010: w_phase = YELLOW;
      default:    w_phase = ILLEGAL;
    endcase
  end

  assign w_dur = CNT_W'(phase_dur(w_phase, T_MGREEN,
    T_SGREEN, T_YELLOW, T_ALLRED, T_PED));

`ifdef PHASE_FAULT_EN
  logic r_ill_q;
  logic r_fault;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ill_q <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      r_ill_q <= (w_phase == ILLEGAL);
      if ((w_phase == ILLEGAL) && r_ill_q) begin
        r_fault <= 1'b1;
      end
    end
  end

  assign w_fault   = r_fault;
  assign w_load_ok = (w_phase != ILLEGAL);
`else
  assign w_fault   = 1'b0;
  assign w_load_ok = 1'b1;
`endif

  tick_prescaler #(
    .CLK_DIV(CLK_DIV)
  ) u_presc (
    .clk   (clk),
    .reset (reset),
    .i_clr (w_clr),
    .o_tick(w_tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= SETTLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // A phase change mid-count reloads at once so the new time shows early
  always_comb begin
    w_state_nx = r_state;
    w_clr      = 1'b0;
    w_reload   = 1'b0;
    case (r_state)
      SETTLE: w_state_nx = LOAD;
      LOAD: begin
        if (w_load_ok) begin
          w_state_nx = COUNT;
          w_clr      = 1'b1;
          w_reload   = 1'b1;
        end
      end
      COUNT: begin
        if (w_phase != r_phase) begin
          w_state_nx = LOAD;
          w_clr      = 1'b1;
          w_reload   = w_load_ok;
        end else if (w_tick && (r_rem == CNT_W'(1))) begin
          w_state_nx = PULSE;
        end
      end
      PULSE:   w_state_nx = SETTLE;
      default: w_state_nx = SETTLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rem   <= '0;
      r_phase <= MGREEN;
    end else if (w_reload) begin
      r_rem   <= w_dur;
      r_phase <= w_phase;
    end else if ((r_state == COUNT) && (w_phase == r_phase)
                 && w_tick) begin
      r_rem <= r_rem - CNT_W'(1);
    end else if (r_state == PULSE) begin
      r_rem <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_nc  <= 1'b0;
      r_cyc <= '0;
    end else begin
      r_nc <= newCycle;
      if (newCycle && !r_nc) begin
        r_cyc <= r_cyc + 8'd1;
      end
    end
  end

  assign en         = (r_state == PULSE) && !w_fault;
  assign tick       = w_tick;
  assign remaining  = w_fault ? '1 : r_rem;
  assign cycleCount = r_cyc;
  assign phaseFault = w_fault;

endmodule

// File: tb/tb_traffic_phase_timer.sv
// Directed bench for traffic_phase_timer with CLK_DIV=4 and short
// phase times; covers timing, reloads, cycle counting and faults.
module tb_traffic_phase_timer;

  localparam logic [6:0] L_MG  = 7'b100_001_0;
  localparam logic [6:0] L_YM  = 7'b010_001_0;
  localparam logic [6:0] L_AR  = 7'b001_001_0;
  localparam logic [6:0] L_SG  = 7'b001_100_0;
  localparam logic [6:0] L_YS  = 7'b001_010_0;
  localparam logic [6:0] L_PED = 7'b001_001_1;
  localparam logic [6:0] L_OFF = 7'b000_000_0;

  logic       clk;
  logic       reset;
  logic       MG, MY, MR, SG, SY, SR, pedLight, newCycle;
  logic       en;
  logic       tick;
  logic [5:0] remaining;
  logic [7:0] cycleCount;
  logic       phaseFault;

  int checks;
  int failures;

  traffic_phase_timer #(
    .CLK_DIV (4),
    .T_MGREEN(3),
    .T_SGREEN(2),
    .T_YELLOW(0),
    .T_ALLRED(1),
    .T_PED   (2),
    .CNT_W   (6)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .MG        (MG),
    .MY        (MY),
    .MR        (MR),
    .SG        (SG),
    .SY        (SY),
    .SR        (SR),
    .pedLight  (pedLight),
    .newCycle  (newCycle),
    .en        (en),
    .tick      (tick),
    .remaining (remaining),
    .cycleCount(cycleCount),
    .phaseFault(phaseFault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick_clk;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_lt(input logic [6:0] lt, input logic nc);
    {MG, MY, MR, SG, SY, SR, pedLight} = lt;
    newCycle = nc;
  endtask

  task automatic wait_en(output int n);
    n = 0;
    do begin
      tick_clk;
      n++;
    end while (en !== 1'b1 && n < 200);
  endtask

  // Called while en is high; emulates the controller stepping on en
  task automatic step_phase(input logic [6:0] lt, input logic nc,
                            input int dur, input string tag);
    int n;
    tick_clk;
    chk({tag, "_en_width"}, 32'(en), 0);
    set_lt(lt, nc);
    wait_en(n);
    chk({tag, "_latency"}, n, 2 + 4 * dur);
  endtask

  initial begin
    logic [5:0] rem_log[15];
    logic       en_log[15];
    logic       tk_log[15];
    int         en_cnt;
    int         n;

    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    set_lt(L_MG, 1'b0);
    repeat (3) tick_clk;

    chk("rst_en", 32'(en), 0);
    chk("rst_tick", 32'(tick), 0);
    chk("rst_remaining", 32'(remaining), 0);
    chk("rst_cycleCount", 32'(cycleCount), 0);
    chk("rst_phaseFault", 32'(phaseFault), 0);

    reset = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      tick_clk;
      rem_log[k] = remaining;
      en_log[k]  = en;
      tk_log[k]  = tick;
    end
    en_cnt = 0;
    for (int k = 1; k <= 13; k++) begin
      if (en_log[k] === 1'b1) en_cnt++;
    end
    chk("mg_no_early_en", en_cnt, 0);
    chk("mg_en_at_14", 32'(en_log[14]), 1);
    chk("mg_rem_3", 32'(rem_log[2]), 3);
    chk("mg_rem_2", 32'(rem_log[6]), 2);
    chk("mg_rem_1", 32'(rem_log[10]), 1);
    chk("mg_rem_0", 32'(rem_log[14]), 0);
    chk("tick_idle", 32'(tk_log[4]), 0);
    chk("tick_wrap", 32'(tk_log[5]), 1);

    step_phase(L_YM, 1'b0, 1, "yel_zero");
    step_phase(L_AR, 1'b0, 1, "allred");
    step_phase(L_SG, 1'b0, 2, "sgreen");
    step_phase(L_YS, 1'b0, 1, "yel_side");
    step_phase(L_AR, 1'b0, 1, "allred2");
    step_phase(L_MG, 1'b1, 3, "mgreen");
    chk("cycle_one", 32'(cycleCount), 1);

    for (int i = 0; i < 255; i++) begin
      step_phase(L_YM, 1'b0, 1, "lp_ym");
      step_phase(L_AR, 1'b0, 1, "lp_ar");
      step_phase(L_SG, 1'b0, 2, "lp_sg");
      step_phase(L_YS, 1'b0, 1, "lp_ys");
      step_phase(L_AR, 1'b0, 1, "lp_ar2");
      step_phase(L_MG, 1'b1, 3, "lp_mg");
    end
    chk("cycle_wrap", 32'(cycleCount), 0);

    step_phase(L_PED, 1'b0, 2, "ped");

    tick_clk;
    chk("mid_en_width", 32'(en), 0);
    set_lt(L_SG, 1'b0);
    repeat (3) tick_clk;
    chk("mid_rem_sg", 32'(remaining), 2);
    set_lt(L_MG, 1'b0);
    repeat (2) tick_clk;
    chk("mid_reload", 32'(remaining), 3);
    chk("mid_no_en", 32'(en), 0);
    wait_en(n);
    chk("mid_latency", n, 13);

    tick_clk;
    set_lt(L_MG, 1'b1);
    repeat (4) tick_clk;
    chk("pre_rst_cycle", 32'(cycleCount), 1);
    reset    = 1'b1;
    newCycle = 1'b0;
    tick_clk;
    chk("midrst_rem", 32'(remaining), 0);
    chk("midrst_en", 32'(en), 0);
    chk("midrst_cycle", 32'(cycleCount), 0);
    reset = 1'b0;
    wait_en(n);
    chk("midrst_latency", n, 14);

`ifdef PHASE_FAULT_EN
    tick_clk;
    set_lt(L_OFF, 1'b0);
    repeat (3) tick_clk;
    chk("fault_set", 32'(phaseFault), 1);
    chk("fault_rem", 32'(remaining), 63);
    en_cnt = 0;
    repeat (20) begin
      tick_clk;
      if (en === 1'b1) en_cnt++;
    end
    chk("fault_no_en", en_cnt, 0);
    chk("fault_sticky", 32'(phaseFault), 1);
    reset = 1'b1;
    tick_clk;
    chk("fault_clear", 32'(phaseFault), 0);
    reset = 1'b0;
`else
    step_phase(L_OFF, 1'b0, 1, "illegal");
    chk("no_fault", 32'(phaseFault), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
